vga_timing_gen: RTL and testbench

- Upstream stage of every sprite/tile renderer. Generates the raster position DrawX/DrawY, the active-video flag `blank`, and the VGA/HDMI sync pulses from the pixel clock.
- Also emits a one-cycle `frame_end` strobe for game logic.
- Sync outputs are delayed by a parameterised number of cycles so they line up with the renderer's registered colour outputs. Default path: ROM read plus output register, 2 cycles.

---
 rtl/vga_timing_gen_pkg.sv | 25 ++
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_timing_gen_sync_delay.sv | 36 +++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: default 640x480@60 raster timing and the shared screen-coordinate type.
// Renderers import this package to get the screen bounds.
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Largest total (line length or frame height) that a 10-bit coordinate can hold.
  localparam int unsigned COORD_MAX_TOTAL = 1023;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam coord_t SCREEN_W = coord_t'(H_ACTIVE_DEF);
  localparam coord_t SCREEN_H = coord_t'(V_ACTIVE_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster/sync bundle from the timing generator to downstream renderers.
// frame_cnt is present only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;

  vga_pkg::coord_t DrawX;
  vga_pkg::coord_t DrawY;
  logic            blank;
  logic            hs;
  logic            vs;
  logic            frame_end;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]     frame_cnt;
`endif

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_end
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_end
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// sync_delay_line: DEPTH-stage shift register that resets to all ones.
// DEPTH=0 is a wire from d to q.
module sync_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_shift
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift one stage toward the output each cycle.
    always_comb begin
      sr_d    = sr_q;
      sr_d[0] = d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end

    // Stage registers; reset to the inactive (high) sync level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '1;
      else        sr_q <= sr_d;
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, blanking, frame strobe and delayed syncs.
// Optional frame counter is enabled with the VGA_FRAME_CNT_EN macro.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > COORD_MAX_TOTAL || V_TOTAL > COORD_MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: line or frame total does not fit a 10-bit counter");
  end
  if (SYNC_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be 0..7");
  end

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT      = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT      = coord_t'(V_ACTIVE);
  localparam coord_t H_ACT_LAST = coord_t'(H_ACTIVE - 1);
  localparam coord_t V_ACT_LAST = coord_t'(V_ACTIVE - 1);
  localparam coord_t HS_FIRST   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   blank_q, blank_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   frame_end_q, frame_end_d;
  logic   hs_dly, vs_dly;

  // Next raster position, and status decoded from that next position so the
  // registered flags line up with the registered counters.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
    blank_d     = (x_d < H_ACT) && (y_d < V_ACT);
    hsync_d     = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d     = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    frame_end_d = (x_d == H_ACT_LAST) && (y_d == V_ACT_LAST);
  end

  // Counter and status registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      blank_q     <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      frame_end_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      blank_q     <= blank_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      frame_end_q <= frame_end_d;
    end
  end

  sync_delay_line #(.DEPTH(SYNC_DELAY)) u_hs_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d     (hsync_q),
    .q     (hs_dly)
  );

  sync_delay_line #(.DEPTH(SYNC_DELAY)) u_vs_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d     (vsync_q),
    .q     (vs_dly)
  );

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Count completed frames; steps on the edge following the frame_end cycle.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_end_q) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // Frame counter register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign vid.frame_cnt = frame_cnt_q;
`endif

  assign vid.DrawX     = x_q;
  assign vid.DrawY     = y_q;
  assign vid.blank     = blank_q;
  assign vid.hs        = hs_dly;
  assign vid.vs        = vs_dly;
  assign vid.frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing (delay 2 and delay 0) plus a tiny 15x8
// raster used for whole-frame behaviour.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  vga_timing_gen_if vid_a ();
  vga_timing_gen_if vid_b ();
  vga_timing_gen_if vid_c ();

  vga_timing_gen u_a (
    .vga_clk (clk),
    .reset_n (reset_n),
    .vid     (vid_a.master)
  );

  // Tiny raster: H total 15 (sync x=10..12), V total 8 (sync y=5..6), frame = 120 cycles.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_DELAY(2)
  ) u_b (
    .vga_clk (clk),
    .reset_n (reset_n),
    .vid     (vid_b.master)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) u_c (
    .vga_clk (clk),
    .reset_n (reset_n),
    .vid     (vid_c.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected delayed syncs for the tiny raster, t = edges since reset release.
  function automatic logic b_hs(int t);
    int tp;
    if (t < 2) return 1'b1;
    tp = (t - 2) % 120;
    return !(((tp % 15) >= 10) && ((tp % 15) <= 12));
  endfunction

  function automatic logic b_vs(int t);
    int tp;
    if (t < 2) return 1'b1;
    tp = (t - 2) % 120;
    return !(((tp / 15) >= 5) && ((tp / 15) <= 6));
  endfunction

  task automatic start_run();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (vid_a.DrawX !== 10'd0) begin bad++; $display("FAIL rst_x got=%0d exp=0", vid_a.DrawX); end
      total++; if (vid_a.DrawY !== 10'd0) begin bad++; $display("FAIL rst_y got=%0d exp=0", vid_a.DrawY); end
      total++; if (vid_a.blank !== 1'b0) begin bad++; $display("FAIL rst_blank got=%b exp=0", vid_a.blank); end
      total++; if (vid_a.hs !== 1'b1 || vid_c.hs !== 1'b1) begin bad++; $display("FAIL rst_hs got=%b/%b exp=1", vid_a.hs, vid_c.hs); end
      total++; if (vid_a.vs !== 1'b1 || vid_b.vs !== 1'b1) begin bad++; $display("FAIL rst_vs got=%b/%b exp=1", vid_a.vs, vid_b.vs); end
      total++; if (vid_a.frame_end !== 1'b0) begin bad++; $display("FAIL rst_fe got=%b exp=0", vid_a.frame_end); end
`ifdef VGA_FRAME_CNT_EN
      total++; if (vid_a.frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_fcnt got=%0d exp=0", vid_a.frame_cnt); end
`endif
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (vid_a.DrawX !== 10'd1) begin bad++; $display("FAIL rel_x got=%0d exp=1", vid_a.DrawX); end
    total++; if (vid_a.DrawY !== 10'd0) begin bad++; $display("FAIL rel_y got=%0d exp=0", vid_a.DrawY); end
    total++; if (vid_a.blank !== 1'b1) begin bad++; $display("FAIL rel_blank got=%b exp=1", vid_a.blank); end
  endtask

  task automatic test_line();
    int ex, ey, low_a, low_c, first_a, first_c;
    logic e_hs_a, e_hs_c;
    low_a = 0; low_c = 0; first_a = -1; first_c = -1;
    start_run();
    for (int t = 1; t <= 801; t++) begin
      @(negedge clk);
      ex = t % 800;
      ey = t / 800;
      e_hs_a = !(ex >= 658 && ex <= 753);
      e_hs_c = !(ex >= 656 && ex <= 751);
      total++; if (vid_a.DrawX !== 10'(ex)) begin bad++; $display("FAIL line_x t=%0d got=%0d exp=%0d", t, vid_a.DrawX, ex); end
      total++; if (vid_a.DrawY !== 10'(ey)) begin bad++; $display("FAIL line_y t=%0d got=%0d exp=%0d", t, vid_a.DrawY, ey); end
      total++; if (vid_a.blank !== (ex < 640)) begin bad++; $display("FAIL line_blank t=%0d got=%b exp=%b", t, vid_a.blank, (ex < 640)); end
      total++; if (vid_a.hs !== e_hs_a) begin bad++; $display("FAIL line_hs t=%0d got=%b exp=%b", t, vid_a.hs, e_hs_a); end
      total++; if (vid_c.hs !== e_hs_c) begin bad++; $display("FAIL line_hs_d0 t=%0d got=%b exp=%b", t, vid_c.hs, e_hs_c); end
      total++; if (vid_a.vs !== 1'b1) begin bad++; $display("FAIL line_vs t=%0d got=%b exp=1", t, vid_a.vs); end
      total++; if (vid_a.frame_end !== 1'b0) begin bad++; $display("FAIL line_fe t=%0d got=%b exp=0", t, vid_a.frame_end); end
      if (t <= 800 && vid_a.hs === 1'b0) begin low_a++; if (first_a < 0) first_a = t; end
      if (t <= 800 && vid_c.hs === 1'b0) begin low_c++; if (first_c < 0) first_c = t; end
    end
    total++; if (low_a != 96) begin bad++; $display("FAIL hs_width got=%0d exp=96", low_a); end
    total++; if (low_c != 96) begin bad++; $display("FAIL hs_width_d0 got=%0d exp=96", low_c); end
    total++; if (first_a != 658) begin bad++; $display("FAIL hs_fall got=%0d exp=658", first_a); end
    total++; if (first_c != 656) begin bad++; $display("FAIL hs_fall_d0 got=%0d exp=656", first_c); end
  endtask

  task automatic test_frame();
    int tm, x, y, exp_pulses, obs_pulses, vs_low, first_fe, last_fe;
    logic e_fe;
    exp_pulses = 0; obs_pulses = 0; vs_low = 0; first_fe = -1; last_fe = -1;
    start_run();
    for (int t = 1; t <= 365; t++) begin
      @(negedge clk);
      tm = t % 120;
      x  = tm % 15;
      y  = tm / 15;
      e_fe = (x == 7) && (y == 3);
      total++; if (vid_b.DrawX !== 10'(x)) begin bad++; $display("FAIL frm_x t=%0d got=%0d exp=%0d", t, vid_b.DrawX, x); end
      total++; if (vid_b.DrawY !== 10'(y)) begin bad++; $display("FAIL frm_y t=%0d got=%0d exp=%0d", t, vid_b.DrawY, y); end
      total++; if (vid_b.blank !== (x < 8 && y < 4)) begin bad++; $display("FAIL frm_blank t=%0d got=%b exp=%b", t, vid_b.blank, (x < 8 && y < 4)); end
      total++; if (vid_b.hs !== b_hs(t)) begin bad++; $display("FAIL frm_hs t=%0d got=%b exp=%b", t, vid_b.hs, b_hs(t)); end
      total++; if (vid_b.vs !== b_vs(t)) begin bad++; $display("FAIL frm_vs t=%0d got=%b exp=%b", t, vid_b.vs, b_vs(t)); end
      total++; if (vid_b.frame_end !== e_fe) begin bad++; $display("FAIL frm_fe t=%0d got=%b exp=%b", t, vid_b.frame_end, e_fe); end
`ifdef VGA_FRAME_CNT_EN
      total++; if (vid_b.frame_cnt !== 16'(exp_pulses)) begin bad++; $display("FAIL frm_cnt t=%0d got=%0d exp=%0d", t, vid_b.frame_cnt, exp_pulses); end
`endif
      if (e_fe) exp_pulses++;
      if (vid_b.frame_end === 1'b1) begin
        obs_pulses++;
        if (first_fe < 0) first_fe = t;
        last_fe = t;
      end
      if (vid_b.vs === 1'b0) vs_low++;
    end
    total++; if (obs_pulses != 3) begin bad++; $display("FAIL fe_count got=%0d exp=3", obs_pulses); end
    total++; if (first_fe != 52) begin bad++; $display("FAIL fe_first got=%0d exp=52", first_fe); end
    total++; if (last_fe - first_fe != 240) begin bad++; $display("FAIL fe_period got=%0d exp=240", last_fe - first_fe); end
    total++; if (vs_low != 90) begin bad++; $display("FAIL vs_width got=%0d exp=90", vs_low); end
    @(negedge clk);
`ifdef VGA_FRAME_CNT_EN
    total++; if (vid_b.frame_cnt !== 16'd3) begin bad++; $display("FAIL fcnt_final got=%0d exp=3", vid_b.frame_cnt); end
`endif
  endtask

  task automatic test_mid_reset();
    start_run();
    repeat (700) @(negedge clk);
    // a sits at (700,0) inside its hs pulse; b at (10,6) inside its vs pulse.
    total++; if (vid_a.hs !== 1'b0 || vid_a.DrawX !== 10'd700) begin bad++; $display("FAIL mid_pre_a got x=%0d hs=%b exp x=700 hs=0", vid_a.DrawX, vid_a.hs); end
    total++; if (vid_b.vs !== 1'b0) begin bad++; $display("FAIL mid_pre_b got vs=%b exp=0", vid_b.vs); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (vid_a.DrawX !== 10'd0 || vid_a.DrawY !== 10'd0) begin bad++; $display("FAIL mid_xy got=%0d,%0d exp=0,0", vid_a.DrawX, vid_a.DrawY); end
    total++; if (vid_a.hs !== 1'b1 || vid_a.vs !== 1'b1) begin bad++; $display("FAIL mid_sync_a got hs=%b vs=%b exp=1,1", vid_a.hs, vid_a.vs); end
    total++; if (vid_b.hs !== 1'b1 || vid_b.vs !== 1'b1) begin bad++; $display("FAIL mid_sync_b got hs=%b vs=%b exp=1,1", vid_b.hs, vid_b.vs); end
    total++; if (vid_a.blank !== 1'b0) begin bad++; $display("FAIL mid_blank got=%b exp=0", vid_a.blank); end
    total++; if (vid_b.DrawX !== 10'd0 || vid_b.DrawY !== 10'd0) begin bad++; $display("FAIL mid_xy_b got=%0d,%0d exp=0,0", vid_b.DrawX, vid_b.DrawY); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      total++; if (vid_a.DrawX !== 10'(t) || vid_a.hs !== 1'b1) begin bad++; $display("FAIL restart_a t=%0d got x=%0d hs=%b exp x=%0d hs=1", t, vid_a.DrawX, vid_a.hs, t); end
      total++; if (vid_b.DrawX !== 10'(t % 15) || vid_b.DrawY !== 10'(t / 15)) begin bad++; $display("FAIL restart_b t=%0d got=%0d,%0d exp=%0d,%0d", t, vid_b.DrawX, vid_b.DrawY, t % 15, t / 15); end
      total++; if (vid_b.hs !== b_hs(t) || vid_b.vs !== 1'b1) begin bad++; $display("FAIL restart_b_sync t=%0d got hs=%b vs=%b exp hs=%b vs=1", t, vid_b.hs, vid_b.vs, b_hs(t)); end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
